multi_phase_pwm: RTL

MULTI_PHASE_PWM -- requirements
Module: multi_phase_pwm

---
 rtl/multi_phase_pwm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multi_phase_pwm.sv
// multi_phase_pwm
//   Multi-phase half-bridge PWM generator with shadowed duty registers,
//   per-phase dead-time insertion and edge- or center-aligned counting.
//
// Ports
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   enable        global output enable (0 forces every FET off)
//   load          one-cycle strobe capturing duty_in into the shadow registers
//   duty_in       packed duties, phase k at [k*(COUNTER_WIDTH+1) +: COUNTER_WIDTH+1]
//   high_z        per-phase float request (both FETs off)
//   pwm_high      registered high-side gate drive
//   pwm_low       registered low-side gate drive
//   period_start  high during every cycle in which the counter is 0
//
// Counter FSM
//   state   | meaning
//   ST_IDLE | first cycle out of reset, counter held at 0
//   ST_UP   | counting up; wraps to 0 (edge) or turns down (center) at MAX_COUNTER
//   ST_DOWN | center mode only, counting down to 1 then back to 0
module multi_phase_pwm #(
  parameter int NUM_PHASES     = 3,
  parameter int COUNTER_WIDTH  = 9,
  parameter int MAX_COUNTER    = 511,
  parameter int DEAD_TIME      = 3,
  parameter int CENTER_ALIGNED = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      enable,
  input  logic                                      load,
  input  logic [NUM_PHASES*(COUNTER_WIDTH+1)-1:0]   duty_in,
  input  logic [NUM_PHASES-1:0]                     high_z,
  output logic [NUM_PHASES-1:0]                     pwm_high,
  output logic [NUM_PHASES-1:0]                     pwm_low,
  output logic                                      period_start
);

  localparam int DW = COUNTER_WIDTH + 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(MAX_COUNTER);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
  localparam logic [7:0]               DT_LOAD = 8'(DEAD_TIME);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [COUNTER_WIDTH-1:0]          r_cnt;
  logic [COUNTER_WIDTH-1:0]          w_cnt_nxt;
  logic [NUM_PHASES*DW-1:0]          r_shadow;
  logic [NUM_PHASES*DW-1:0]          r_active;
  logic [NUM_PHASES-1:0]             w_ideal;
  logic [NUM_PHASES-1:0]             r_ideal_prev;
  logic [NUM_PHASES-1:0]             w_drive;
  logic [7:0]                        r_dt     [NUM_PHASES];
  logic [7:0]                        w_dt_nxt [NUM_PHASES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_UP;
        w_cnt_nxt   = '0;
      end
      ST_UP: begin
        if (r_cnt == CNT_MAX) begin
          if (CENTER_ALIGNED != 0) begin
            w_state_nxt = ST_DOWN;
            w_cnt_nxt   = CNT_MAX - CNT_ONE;
          end else begin
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_UP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign period_start = (r_cnt == '0) && (r_state != ST_IDLE);

  // Active duties are swapped in on the edge that enters counter==0 so the
  // new value already governs the compare of the first cycle of the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (load) begin
        r_shadow <= duty_in;
      end
      if (w_cnt_nxt == '0) begin
        r_active <= r_shadow;
      end
    end
  end

  // Dead-time: any change in the ideal level (or a float/disable request)
  // reloads the counter; a side is only driven once the counter has run out.
  always_comb begin
    for (int k = 0; k < NUM_PHASES; k++) begin
      w_ideal[k]  = ({1'b0, r_cnt} < r_active[k*DW +: DW]);
      w_dt_nxt[k] = r_dt[k];
      if (high_z[k] || !enable || (w_ideal[k] != r_ideal_prev[k])) begin
        w_dt_nxt[k] = DT_LOAD;
      end else if (r_dt[k] != 8'd0) begin
        w_dt_nxt[k] = r_dt[k] - 8'd1;
      end
      w_drive[k] = (w_dt_nxt[k] == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ideal_prev <= '0;
      pwm_high     <= '0;
      pwm_low      <= '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        r_dt[k] <= DT_LOAD;
      end
    end else begin
      r_ideal_prev <= w_ideal;
      pwm_high     <= w_drive & w_ideal;
      pwm_low      <= w_drive & ~w_ideal;
      for (int k = 0; k < NUM_PHASES; k++) begin
        r_dt[k] <= w_dt_nxt[k];
      end
    end
  end

endmodule
